// File: rtl/ldst_const_cache_mc.sv
// Multi-cycle constant cache for one MP: serialises a warp request over its distinct
// active-lane addresses, one constant-BRAM read per distinct address, and returns per-lane words.
module ldst_const_cache_mc #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 10,
  parameter int SP_PER_MP  = 8,
  parameter int SP_DEPTH   = $clog2(SP_PER_MP)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [ADDR_WIDTH-1:0] addrs [SP_PER_MP],
  input  logic [SP_PER_MP-1:0]  cur_mask,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic [DATA_WIDTH-1:0] const_data [SP_PER_MP],
  output logic [SP_PER_MP-1:0]  resp_mask,
  output logic [SP_DEPTH:0]     passes,
  input  logic                  cwe_gs,
  input  logic [ADDR_WIDTH-1:0] caddr_gs,
  input  logic [DATA_WIDTH-1:0] cdata_gs,
  output logic [1:0]            dbg_state_o
);

  // Handshakes: a transfer happens on a rising edge where valid && ready. The request side is
  // ready only in IDLE; the response is held unchanged while resp_valid && !resp_ready.

  typedef enum logic [1:0] {IDLE, SERVE, DRAIN, RESP} state_t;

  localparam logic [SP_DEPTH:0] PASS_ONE = 1;

  state_t                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   addr_q [SP_PER_MP];
  logic [DATA_WIDTH-1:0]   data_q [SP_PER_MP];
  logic [SP_PER_MP-1:0]    pending_q, pending_d;
  logic [SP_PER_MP-1:0]    issue_mask_q, issue_mask_d;
  logic                    issue_v_q, issue_v_d;
  logic [SP_DEPTH:0]       passes_q, passes_d;
  logic [SP_PER_MP-1:0]    resp_mask_q;
  logic [SP_DEPTH-1:0]     sel;
  logic [SP_PER_MP-1:0]    hit;
  logic                    accept;
  logic                    rd_en;
  logic [DATA_WIDTH-1:0]   mem [2**ADDR_WIDTH];
  logic [DATA_WIDTH-1:0]   dout_q;

  assign accept = req_valid && (state_q == IDLE);
  // A global-scheduler write stalls the read so the two BRAM ports never collide on one edge.
  assign rd_en  = (state_q == SERVE) && !cwe_gs;

  always_comb begin
    sel = '0;
    for (int i = SP_PER_MP - 1; i >= 0; i--) begin
      if (pending_q[i]) sel = SP_DEPTH'(i);
    end
    hit = '0;
    for (int i = 0; i < SP_PER_MP; i++) begin
      hit[i] = pending_q[i] && (addr_q[i] == addr_q[sel]);
    end
  end

  always_comb begin
    state_d      = state_q;
    pending_d    = pending_q;
    issue_mask_d = issue_mask_q;
    issue_v_d    = 1'b0;
    passes_d     = passes_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          pending_d = cur_mask;
          passes_d  = '0;
          state_d   = (cur_mask == '0) ? RESP : SERVE;
        end
      end
      SERVE: begin
        if (rd_en) begin
          pending_d    = pending_q & ~hit;
          issue_mask_d = hit;
          issue_v_d    = 1'b1;
          passes_d     = passes_q + PASS_ONE;
          if ((pending_q & ~hit) == '0) state_d = DRAIN;
        end
      end
      DRAIN: state_d = RESP;
      RESP: begin
        if (resp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      pending_q    <= '0;
      issue_mask_q <= '0;
      issue_v_q    <= 1'b0;
      passes_q     <= '0;
    end else begin
      state_q      <= state_d;
      pending_q    <= pending_d;
      issue_mask_q <= issue_mask_d;
      issue_v_q    <= issue_v_d;
      passes_q     <= passes_d;
    end
  end

  // Lanes load the word one edge after their read issued; lanes never hit stay zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      resp_mask_q <= '0;
      for (int i = 0; i < SP_PER_MP; i++) begin
        addr_q[i] <= '0;
        data_q[i] <= '0;
      end
    end else if (accept) begin
      resp_mask_q <= cur_mask;
      for (int i = 0; i < SP_PER_MP; i++) begin
        addr_q[i] <= addrs[i];
        data_q[i] <= '0;
      end
    end else if (issue_v_q) begin
      for (int i = 0; i < SP_PER_MP; i++) begin
        if (issue_mask_q[i]) data_q[i] <= dout_q;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (cwe_gs) mem[caddr_gs] <= cdata_gs;
    if (rd_en) dout_q <= mem[addr_q[sel]];
  end

  assign req_ready   = (state_q == IDLE);
  assign resp_valid  = (state_q == RESP);
  assign const_data  = data_q;
  assign resp_mask   = resp_mask_q;
  assign passes      = passes_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_ldst_const_cache_mc.sv
// Bench for ldst_const_cache_mc: shadow constant memory, vector table, expected-response queue,
// plus hand-written write-stall, held-response and mid-serve reset sequences.
module tb_ldst_const_cache_mc;
  localparam int DW = 32;
  localparam int AW = 10;
  localparam int SP = 8;
  localparam int SD = 3;
  localparam int RW = SP + SD + 1 + SP * DW;
  localparam int NV = 10;

  logic          clk = 1'b0;
  logic          rst;
  logic          req_valid, req_ready, resp_valid, resp_ready;
  logic [AW-1:0] addrs [SP];
  logic [SP-1:0] cur_mask, resp_mask;
  logic [DW-1:0] const_data [SP];
  logic [SD:0]   passes;
  logic          cwe_gs;
  logic [AW-1:0] caddr_gs;
  logic [DW-1:0] cdata_gs;
  logic [1:0]    dbg_state;

  always #5 clk = ~clk;

  ldst_const_cache_mc dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .addrs(addrs), .cur_mask(cur_mask),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .const_data(const_data), .resp_mask(resp_mask), .passes(passes),
    .cwe_gs(cwe_gs), .caddr_gs(caddr_gs), .cdata_gs(cdata_gs),
    .dbg_state_o(dbg_state)
  );

  typedef struct {
    logic [AW-1:0] a [SP];
    logic [SP-1:0] m;
    int            exp_passes;
    int            exp_cyc;
  } vec_t;

  logic [RW-1:0] exp_q [$];
  logic [DW-1:0] mem_m [1 << AW];
  vec_t          vecs [NV];
  logic [AW-1:0] ta [SP];
  int            n_tests = 0;
  int            n_fail  = 0;

  task automatic chk(input string name, input logic [RW-1:0] act, input logic [RW-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [RW-1:0] pack_act();
    logic [RW-1:0] v;
    v = '0;
    for (int i = 0; i < SP; i++) v[i*DW +: DW] = const_data[i];
    v[SP*DW +: SD+1]      = passes;
    v[SP*DW+SD+1 +: SP]   = resp_mask;
    return v;
  endfunction

  function automatic logic [RW-1:0] model(input logic [AW-1:0] a [SP], input logic [SP-1:0] m,
                                          input int np);
    logic [RW-1:0] v;
    v = '0;
    for (int i = 0; i < SP; i++) v[i*DW +: DW] = m[i] ? mem_m[a[i]] : '0;
    v[SP*DW +: SD+1]    = np[SD:0];
    v[SP*DW+SD+1 +: SP] = m;
    return v;
  endfunction

  function automatic int distinct(input logic [AW-1:0] a [SP], input logic [SP-1:0] m);
    int n;
    bit seen;
    n = 0;
    for (int i = 0; i < SP; i++) begin
      if (m[i]) begin
        seen = 1'b0;
        for (int j = 0; j < i; j++) if (m[j] && a[j] == a[i]) seen = 1'b1;
        if (!seen) n++;
      end
    end
    return n;
  endfunction

  task automatic write_mem(input logic [AW-1:0] wa, input logic [DW-1:0] wd);
    cwe_gs = 1'b1; caddr_gs = wa; cdata_gs = wd;
    @(negedge clk);
    cwe_gs = 1'b0;
    mem_m[wa] = wd;
  endtask

  // Called at a falling edge with the DUT idle. wr_cyc != 0 drives one write in that cycle.
  task automatic run_req(input string name, input logic [AW-1:0] a [SP], input logic [SP-1:0] m,
                         input int exp_passes, input int exp_cyc, input int wr_cyc,
                         input logic [AW-1:0] wa, input logic [DW-1:0] wd, input bit hold);
    int cyc;
    logic [RW-1:0] e;
    if (wr_cyc != 0) mem_m[wa] = wd;  // the write lands before that address is read
    exp_q.push_back(model(a, m, exp_passes));
    addrs = a; cur_mask = m; req_valid = 1'b1; resp_ready = !hold;
    chk({name, "/req_ready"}, RW'(req_ready), RW'(1'b1));
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    cyc = 1;
    while (cyc < 40) begin
      cwe_gs = (wr_cyc != 0) && (cyc == wr_cyc);
      caddr_gs = wa; cdata_gs = wd;
      if (resp_valid) break;
      @(negedge clk);
      cyc++;
    end
    cwe_gs = 1'b0;
    chk({name, "/latency"}, RW'(cyc), RW'(exp_cyc));
    e = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
    if (hold) begin
      req_valid = 1'b1;
      for (int k = 0; k < 4; k++) begin
        chk({name, "/held_resp"}, pack_act(), e);
        chk({name, "/held_flags"}, RW'({resp_valid, req_ready}), RW'(2'b10));
        @(negedge clk);
      end
      req_valid = 1'b0; resp_ready = 1'b1;
    end
    chk({name, "/resp"}, pack_act(), e);
    @(posedge clk);
    @(negedge clk);
    chk({name, "/release"}, RW'({resp_valid, req_ready}), RW'(2'b01));
  endtask

  initial begin
    rst = 1'b1; req_valid = 1'b0; resp_ready = 1'b1; cur_mask = '0;
    cwe_gs = 1'b0; caddr_gs = '0; cdata_gs = '0;
    for (int i = 0; i < SP; i++) addrs[i] = '0;

    // Vector table: fixed corner rows then random rows with repeated addresses.
    for (int i = 0; i < SP; i++) vecs[0].a[i] = AW'(i);
    vecs[0].m = 8'hFF; vecs[0].exp_passes = 8; vecs[0].exp_cyc = 10;
    for (int i = 0; i < SP; i++) vecs[1].a[i] = AW'(12);
    vecs[1].a[0] = AW'(7); vecs[1].a[1] = AW'(3);
    vecs[1].a[2] = AW'(7); vecs[1].a[5] = AW'(7); vecs[1].a[7] = AW'(3);
    vecs[1].m = 8'hA4; vecs[1].exp_passes = 2; vecs[1].exp_cyc = 4;
    for (int i = 0; i < SP; i++) vecs[2].a[i] = AW'(i + 1);
    vecs[2].m = 8'h00; vecs[2].exp_passes = 0; vecs[2].exp_cyc = 1;
    for (int r = 3; r < NV; r++) begin
      for (int i = 0; i < SP; i++) vecs[r].a[i] = AW'($urandom_range(0, 3));
      vecs[r].m = SP'($urandom_range(1, 255));
      vecs[r].exp_passes = distinct(vecs[r].a, vecs[r].m);
      vecs[r].exp_cyc = vecs[r].exp_passes + 2;
    end

    repeat (2) @(negedge clk);
    chk("reset/outputs", pack_act(), '0);
    chk("reset/flags", RW'({resp_valid, req_ready}), RW'(2'b01));
    rst = 1'b0;
    @(negedge clk);

    write_mem(AW'(5), 32'hA5A5A5A5);
    for (int i = 0; i < SP; i++) ta[i] = AW'(5);
    run_req("broadcast", ta, 8'hFF, 1, 3, 0, '0, '0, 1'b0);

    for (int i = 0; i < SP; i++) write_mem(AW'(i), 32'h100 + i);
    for (int r = 0; r < NV; r++)
      run_req($sformatf("vec%0d", r), vecs[r].a, vecs[r].m, vecs[r].exp_passes,
              vecs[r].exp_cyc, 0, '0, '0, 1'b0);

    for (int i = 0; i < SP; i++) ta[i] = AW'(9);
    ta[0] = AW'(1); ta[1] = AW'(2);
    run_req("write_stall", ta, 8'h03, 2, 5, 2, AW'(2), 32'h0000DEAD, 1'b0);

    run_req("hold", vecs[0].a, 8'hFF, 8, 10, 0, '0, '0, 1'b1);

    // Reset in the middle of SERVE drops the request without a response.
    addrs = vecs[0].a; cur_mask = 8'hFF; req_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("midreset/outputs", pack_act(), '0);
    chk("midreset/flags", RW'({resp_valid, req_ready}), RW'(2'b01));
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    run_req("after_reset", vecs[1].a, vecs[1].m, 2, 4, 0, '0, '0, 1'b0);

    chk("scoreboard_empty", RW'(exp_q.size()), '0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/ldst_const_cache_mc.md
Name: ldst_const_cache_mc

Overview:
- Multi-cycle constant cache for one MP; replaces single-address broadcast.
- Accepts one warp request (per-SP addresses plus active mask) and serialises over the distinct addresses among active lanes, one BRAM read per distinct address.
- Every active lane whose address matches the current read receives the returned word, so each lane gets its own constant even when the warp diverges in address.
- Sits between the LD/ST issue stage and the writeback mux. Global-scheduler writes share the 1R1W constant BRAM.

Parameters:
- DATA_WIDTH, 32, constant word width
- ADDR_WIDTH, 10, constant memory address width (depth 2**ADDR_WIDTH)
- SP_PER_MP, 8, lanes per warp slice
- SP_DEPTH, $clog2(SP_PER_MP), lane index width

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- req_valid  in  1  request present
- req_ready  out  1  block can accept a request
- addrs  in  ADDR_WIDTH x SP_PER_MP (unpacked)  per-lane read addresses
- cur_mask  in  SP_PER_MP  active-lane mask
- resp_valid  out  1  response data valid
- resp_ready  in  1  consumer accepts response
- const_data  out  DATA_WIDTH x SP_PER_MP (unpacked)  per-lane read data
- resp_mask  out  SP_PER_MP  copy of accepted cur_mask
- passes  out  SP_DEPTH+1  BRAM reads used for this response
- cwe_gs  in  1  constant write enable from global scheduler
- caddr_gs  in  ADDR_WIDTH  constant write address
- cdata_gs  in  DATA_WIDTH  constant write data

Behaviour:
- Reset (async, high):
  - state=IDLE; resp_valid=0; const_data all 0; resp_mask=0; passes=0.
  - Internal pending/issue masks cleared.
  - BRAM contents are not reset.
  - Reset mid-operation aborts the request with no response.
- req_ready = (state==IDLE). It is 1 during and after reset.
- Handshake:
  - A request is accepted on the edge where req_valid&&req_ready.
  - At acceptance, addrs and cur_mask are latched, pending=cur_mask, const_data regs cleared to 0, passes=0.
  - The response is held stable while resp_valid&&!resp_ready.
- States: IDLE, SERVE, DRAIN, RESP.
- IDLE -> SERVE on accept if cur_mask!=0. IDLE -> RESP on accept if cur_mask==0 (passes=0, all data 0).
- SERVE, each cycle with cwe_gs=0:
  - sel = lowest set bit of pending.
  - ra = addr[sel].
  - hit = pending lanes whose latched addr equals addr[sel].
  - pending &= ~hit; issue_mask_q <= hit; issue_v_q <= 1; passes++.
  - When the new pending==0, go to DRAIN.
- SERVE with cwe_gs=1: no read is issued (stall); issue_v_q <= 0; pending unchanged. Writes therefore never coincide with a read.
- Capture: BRAM read latency is 1 cycle. When issue_v_q=1, lanes in issue_mask_q load dout at the next edge. Unmasked lanes stay 0.
- DRAIN: capture the final read, then go to RESP.
- RESP: resp_valid=1; go to IDLE on resp_ready.
- cwe_gs writes are accepted in every state, including IDLE and RESP.
- Latency: accept at edge of cycle 0, N distinct addresses, S write-stall cycles → resp_valid first high in cycle N+S+2. Masked-off requests respond in cycle 1.
- Write/read ordering:
  - An address written before its read issues returns the new data.
  - An address already issued returns the old data.
- passes never exceeds SP_PER_MP. Addresses of inactive lanes are ignored for matching.

Test Plan:
- Preload mem[5]=0xA5A5A5A5. Request: all 8 lanes addr 5, mask 0xFF → resp_valid in cycle 3; all lanes 0xA5A5A5A5; passes=1; resp_mask=0xFF.
- Preload mem[i]=0x100+i. Request: lane i addr i, mask 0xFF → resp in cycle 10; lane i = 0x100+i; passes=8.
- Mask 0xA4, lanes 2/5 addr 7, lane 7 addr 3 → passes=2; lanes 2,5 = mem[7]; lane 7 = mem[3]; other lanes 0; resp in cycle 4.
- Lane 0 addr 1, lane 1 addr 2. Assert cwe_gs writing mem[2]=0xDEAD in the cycle the second read would issue → one stall cycle; lane 1 = 0xDEAD; resp in cycle 5.
- Hold resp_ready=0 for 4 cycles → resp_valid, const_data, passes stable, req_ready=0. The next request is accepted only after the resp_ready edge.
- Assert rst during SERVE → all outputs 0 immediately, req_ready=1. A new request afterwards completes normally with correct data.
